// File: rtl/output_buffer.sv
// Output stage: collects one processed pixel per flow cycle per column,
// drops warm-up/padding rows and emits valid pixels as an AXI-Stream master.
module output_buffer #(
    parameter int DATA_WIDTH         = 8,
    parameter int C_AXIS_TDATA_WIDTH = 32,
    parameter int OUTPUT_HEIGHT      = 480,
    parameter int OUTPUT_WIDTH       = 640,
    parameter int LATENCY            = 1
) (
    input  logic                            aclk,
    input  logic                            aresetn,
    input  logic                            data_flowing,
    input  logic                            is_full_columns_first_input,
    input  logic [DATA_WIDTH-1:0]           pixel_R,
    input  logic [DATA_WIDTH-1:0]           pixel_G,
    input  logic [DATA_WIDTH-1:0]           pixel_B,
    output logic                            output_has_back_pressure,
    output logic                            m_tvalid,
    input  logic                            m_tready,
    output logic [C_AXIS_TDATA_WIDTH-1:0]   m_tdata,
    output logic [C_AXIS_TDATA_WIDTH/8-1:0] m_tstrb,
    output logic                            m_tlast,
    output logic                            sync_error
);

    localparam int RW = (OUTPUT_HEIGHT > 1) ? $clog2(OUTPUT_HEIGHT) : 1;
    localparam int CW = (OUTPUT_WIDTH > 1) ? $clog2(OUTPUT_WIDTH) : 1;

    localparam logic [RW-1:0] ROW_LAST = RW'(OUTPUT_HEIGHT - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(OUTPUT_WIDTH - 1);

    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] CAPTURE = 1'b1;

    logic [LATENCY-1:0]            delay_q;
    logic [0:0]                    state;
    logic [RW-1:0]                 row_cnt;
    logic [CW-1:0]                 col_cnt;
    logic                          start;
    logic                          load;
    logic                          row_last;
    logic                          col_last;
    logic [C_AXIS_TDATA_WIDTH-1:0] beat;

    assign start    = data_flowing && delay_q[LATENCY-1];
    assign load     = data_flowing && (state == CAPTURE || start);
    assign row_last = (row_cnt == ROW_LAST);
    assign col_last = (col_cnt == COL_LAST);

    assign output_has_back_pressure = m_tvalid && !m_tready;
    assign m_tstrb = '1;

    // Pack the pixel into the top of the beat, zero-filling the low bits.
    always_comb begin
        beat = '0;
        beat[C_AXIS_TDATA_WIDTH-1 -: 3*DATA_WIDTH] = {pixel_R, pixel_G, pixel_B};
    end

    // Marker delay line aligning the column start with the row-0 result.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            delay_q <= '0;
        end else if (data_flowing) begin
            delay_q[0] <= is_full_columns_first_input;
            for (int k = 1; k < LATENCY; k++) begin
                delay_q[k] <= delay_q[k-1];
            end
        end
    end

    // Column FSM and row/column counters; a start while capturing only flags an error.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state      <= IDLE;
            row_cnt    <= '0;
            col_cnt    <= '0;
            sync_error <= 1'b0;
        end else begin
            if (start && state == CAPTURE) begin
                sync_error <= 1'b1;
            end
            if (load) begin
                if (row_last) begin
                    row_cnt <= '0;
                    col_cnt <= col_last ? '0 : col_cnt + 1'b1;
                    state   <= IDLE;
                end else begin
                    row_cnt <= row_cnt + 1'b1;
                    state   <= CAPTURE;
                end
            end
        end
    end

    // Single-stage output register; upstream never flows while a beat is stalled.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            m_tvalid <= 1'b0;
            m_tlast  <= 1'b0;
            m_tdata  <= '0;
        end else if (load) begin
            m_tvalid <= 1'b1;
            m_tdata  <= beat;
            m_tlast  <= row_last && col_last;
        end else if (m_tready) begin
            m_tvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_output_buffer.sv
// Scoreboard bench for output_buffer: directed column scenarios followed
// by randomized flow/ready/marker traffic against a column-level model.
module tb_output_buffer;

    localparam int H = 4;
    localparam int W = 2;
    localparam int L = 1;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } beat_t;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        data_flowing = 1'b0;
    logic        marker = 1'b0;
    logic [7:0]  pixel_R = '0;
    logic [7:0]  pixel_G = '0;
    logic [7:0]  pixel_B = '0;
    logic        output_has_back_pressure;
    logic        m_tvalid;
    logic        m_tready = 1'b0;
    logic [31:0] m_tdata;
    logic [3:0]  m_tstrb;
    logic        m_tlast;
    logic        sync_error;

    beat_t q[$];
    beat_t pend[$];
    logic  hist[$];
    int    rem = 0;
    int    col_m = 0;
    logic  sync_exp = 1'b0;
    logic  sync_nxt = 1'b0;
    int    pass_cnt = 0;
    int    tot_cnt = 0;

    output_buffer #(
        .DATA_WIDTH(8),
        .C_AXIS_TDATA_WIDTH(32),
        .OUTPUT_HEIGHT(H),
        .OUTPUT_WIDTH(W),
        .LATENCY(L)
    ) dut (
        .aclk(aclk),
        .aresetn(aresetn),
        .data_flowing(data_flowing),
        .is_full_columns_first_input(marker),
        .pixel_R(pixel_R),
        .pixel_G(pixel_G),
        .pixel_B(pixel_B),
        .output_has_back_pressure(output_has_back_pressure),
        .m_tvalid(m_tvalid),
        .m_tready(m_tready),
        .m_tdata(m_tdata),
        .m_tstrb(m_tstrb),
        .m_tlast(m_tlast),
        .sync_error(sync_error)
    );

    always #5 aclk = ~aclk;

    function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
        tot_cnt++;
        if (a === e) pass_cnt++;
        else $display("FAIL %s got %h expected %h", n, a, e);
    endfunction

    function automatic void emit(int row, logic [23:0] px);
        beat_t b;
        b.data = {px, 8'h00};
        b.last = (row == H - 1) && (col_m == W - 1);
        if (row == H - 1) col_m = (col_m + 1) % W;
        pend.push_back(b);
    endfunction

    // Monitor: compare presented beat to scoreboard head, pop on handshake.
    always @(negedge aclk) begin
        if (aresetn) begin
            chk("tvalid", {31'b0, m_tvalid}, {31'b0, q.size() > 0});
            chk("back_pressure", {31'b0, output_has_back_pressure},
                {31'b0, (q.size() > 0) && !m_tready});
            if (q.size() > 0) begin
                chk("tdata", m_tdata, q[0].data);
                chk("tlast", {31'b0, m_tlast}, {31'b0, q[0].last});
                if (m_tready) void'(q.pop_front());
            end
        end
    end

    task automatic step(input logic mk, input logic fl, input logic rdy,
                        input logic [23:0] px);
        logic flow;
        logic st;
        @(posedge aclk);
        #1;
        while (pend.size() > 0) q.push_back(pend.pop_front());
        sync_exp = sync_nxt;
        chk("sync_error", {31'b0, sync_error}, {31'b0, sync_exp});
        flow = fl && !((q.size() > 0) && !rdy);
        m_tready = rdy;
        data_flowing = flow;
        marker = mk;
        {pixel_R, pixel_G, pixel_B} = px;
        if (flow) begin
            hist.push_back(mk);
            st = 1'b0;
            if (hist.size() > L) st = hist[hist.size() - 1 - L];
            if (rem > 0) begin
                emit(H - rem, px);
                rem--;
                if (st) sync_nxt = 1'b1;
            end else if (st) begin
                emit(0, px);
                rem = H - 1;
            end
        end
    endtask

    task automatic run_col();
        step(1'b1, 1'b1, 1'b1, 24'($urandom));
        for (int i = 0; i < H; i++) step(1'b0, 1'b1, 1'b1, 24'($urandom));
    endtask

    task automatic reset_mid();
        @(posedge aclk);
        #1;
        while (pend.size() > 0) q.push_back(pend.pop_front());
        chk("pre_reset_stall", {31'b0, m_tvalid}, 32'd1);
        aresetn = 1'b0;
        m_tready = 1'b0;
        data_flowing = 1'b0;
        marker = 1'b0;
        @(posedge aclk);
        #1;
        q.delete();
        pend.delete();
        hist.delete();
        rem = 0;
        col_m = 0;
        sync_exp = 1'b0;
        sync_nxt = 1'b0;
        chk("rst_tvalid", {31'b0, m_tvalid}, 32'd0);
        chk("rst_bp", {31'b0, output_has_back_pressure}, 32'd0);
        chk("rst_sync", {31'b0, sync_error}, 32'd0);
        chk("rst_tlast", {31'b0, m_tlast}, 32'd0);
        aresetn = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge aclk);
        #1;
        chk("reset_tvalid", {31'b0, m_tvalid}, 32'd0);
        chk("reset_tlast", {31'b0, m_tlast}, 32'd0);
        chk("reset_tdata", m_tdata, 32'd0);
        chk("reset_sync", {31'b0, sync_error}, 32'd0);
        chk("tstrb", {28'b0, m_tstrb}, 32'hF);
        aresetn = 1'b1;

        // Marker with R=1, then R=2..5: four beats R=2..5, then idle.
        step(1'b1, 1'b1, 1'b1, {8'd1, 16'h0});
        for (int i = 2; i <= 5; i++) step(1'b0, 1'b1, 1'b1, {8'(i), 16'h0});
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 24'h0);

        // Stall beat 2 for three cycles.
        for (int i = 0; i < 10; i++)
            step(i == 0, 1'b1, !(i inside {4, 5, 6}), 24'($urandom));

        // Several columns exercise tlast and column wrap.
        for (int c = 0; c < 3; c++) run_col();

        // Flow toggling during capture.
        step(1'b1, 1'b1, 1'b1, 24'($urandom));
        for (int i = 0; i < 10; i++) step(1'b0, i[0] == 1'b0, 1'b1, 24'($urandom));

        // Second marker early in capture.
        step(1'b1, 1'b1, 1'b1, 24'($urandom));
        step(1'b0, 1'b1, 1'b1, 24'($urandom));
        step(1'b1, 1'b1, 1'b1, 24'($urandom));
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b1, 24'($urandom));

        // Reset with a stalled beat 2 pending.
        step(1'b1, 1'b1, 1'b1, 24'($urandom));
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 24'($urandom));
        reset_mid();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 24'($urandom));

        // Random traffic.
        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 3) != 0, 24'($urandom));

        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 24'h0);
        chk("drained", q.size() + pend.size(), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
